md_issue_buffer: RTL and testbench
==================================

Name: md_issue_buffer

Overview:
- Small in-order FIFO between the E-stage instruction issue and the hi/lo multiply/divide unit.
- Accepts multiply, divide, madd, mthi and mtlo operations from the pipeline without stalling.
- Issues each operation to the MD unit only when that unit reports not-busy.
- Produces the read-stall for mfhi/mflo until every queued and in-flight operation has retired, so hi/lo are read in program order.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears the queue
- in_valid  in  1  E-stage presents an MD operation this cycle
- in_op  in  3  MDOp encoding: 000 multu, 001 mult, 010 divu, 011 div, 110 madd, 100 mthi, 101 mtlo, 111 none
- in_a  in  32  rs operand
- in_b  in  32  rt operand
- in_ready  out  1  queue can accept an entry this cycle
- md_busy  in  1  Busy from the MD unit
- md_start  out  1  Start to the MD unit
- md_op  out  3  MDOp to the MD unit
- md_a  out  32  A to the MD unit
- md_b  out  32  B to the MD unit
- rd_req  in  1  an mfhi/mflo is in E this cycle
- rd_stall  out  1  hold the pipeline; the hi/lo read is not yet safe
- occupancy  out  AW+1  current entry count

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries, each {op[2:0], a[31:0], b[31:0]}.
  - Write and read pointers are AW bits and wrap modulo DEPTH.
  - count is AW+1 bits.
- Reset values: count=0, pointers=0, occupancy=0, md_start=0, md_op=3'b111, md_a=0, md_b=0, rd_stall=rd_req&md_busy.
  - Entry contents after reset are don't-care.
- in_ready = (count != DEPTH).
  - It does not depend on a same-cycle pop. A full queue refuses a push even in a pop cycle.
- Push happens when in_valid & in_ready & (in_op != 3'b111).
  - in_op=111 with in_valid is silently discarded and nothing is stored.
  - in_valid & !in_ready is the upstream's error; the operation is not stored and the upstream must hold the instruction.
- Issue:
  - Condition: issue = (count != 0) & !md_busy.
  - All issue outputs are combinational from the head entry. The head is popped at the clock edge ending the issue cycle.
  - Head op in {000,001,010,011,110}: md_start=1, md_op=op, md_a=a, md_b=b.
  - Head op in {100,101}: md_start=0, md_op=op, md_a=a, md_b=0. The MD unit writes hi or lo at that edge.
  - No issue: md_start=0, md_op=3'b111, md_a=0, md_b=0. Op 111 without Start leaves hi/lo untouched and lets the busy counter decrement.
- Latency and rate:
  - An entry pushed at edge N is issuable no earlier than the cycle after N; there is no bypass.
  - At most one issue per cycle.
  - After a start op, md_busy rises the next cycle and blocks further issue for its 5 or 10 cycles.
  - Back-to-back mthi/mtlo issue every cycle.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
- Read hazard: rd_stall = rd_req & ((count != 0) | md_busy).
  - A read in the cycle of the final pop still stalls, because count is still nonzero.
  - The next cycle is clear for mthi/mtlo.
  - For start ops the next cycle stalls on md_busy.
- Reset mid-operation:
  - The queue empties in the same edge and queued operations are lost.
  - The MD unit's busy counter is not cleared by reset. The buffer keeps honouring md_busy after reset and issues nothing until md_busy=0.
- occupancy = count, registered.

Test Plan:
- Push multu a=3,b=5 on an idle unit.
  - Next cycle: md_start=1, md_op=000, md_a=3, md_b=5, occupancy 1→0.
  - rd_req held high stalls until md_busy falls. The MD unit then holds hi=0, lo=15.
- Push div a=-7,b=2, then mthi a=0x1234 on the following cycle.
  - mthi is not issued until md_busy=0 after the 10-cycle divide.
  - Final state: hi=0x1234, lo=-3.
- Push DEPTH entries while md_busy=1.
  - in_ready=0 at occupancy 4; a fifth in_valid is not stored.
  - Drop md_busy: entries issue in push order with correct operands, and pointers wrap cleanly after 4.
- Simultaneous push and pop at occupancy 2: occupancy stays 2 and the issued entry is the oldest one.
- in_valid with in_op=111: occupancy unchanged, no md_start.
- Assert reset with occupancy 3 and md_busy=1: occupancy=0 next cycle; md_op=111 and md_start=0 until a new push and md_busy=0.

Source files
------------

// File: rtl/md_issue_buffer.sv
// In-order issue queue between the E-stage and the hi/lo multiply/divide unit.
// Latency: an op pushed at edge N can issue in cycle N+1 at the earliest (no bypass).
//          The issue outputs are combinational from the head entry.
// Backpressure: in_ready drops when the queue is full. Issue waits while md_busy is high.
//               rd_stall holds mfhi/mflo until the queue is empty and the unit is idle.
// Ports: clk/reset (sync, active-high) | in_valid/in_op/in_a/in_b/in_ready (push side)
//        md_busy/md_start/md_op/md_a/md_b (MD unit) | rd_req/rd_stall (hi/lo read hazard)
//        occupancy (registered entry count)
module md_issue_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [2:0]    in_op,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  output logic          in_ready,
  input  logic          md_busy,
  output logic          md_start,
  output logic [2:0]    md_op,
  output logic [31:0]   md_a,
  output logic [31:0]   md_b,
  input  logic          rd_req,
  output logic          rd_stall,
  output logic [AW:0]   occupancy
);

  localparam logic [2:0]  OP_MTHI  = 3'b100;
  localparam logic [2:0]  OP_MTLO  = 3'b101;
  localparam logic [2:0]  OP_NONE  = 3'b111;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          issue;

  // Full queue refuses a push even when the head is leaving this cycle; this
  // keeps in_ready independent of md_busy and avoids a long combinational path.
  assign in_ready  = (count != FULL_CNT);
  assign push      = in_valid & in_ready & (in_op != OP_NONE);
  assign issue     = (count != '0) & ~md_busy;
  assign occupancy = count;

  // Stall while anything is queued (including the entry popping this cycle)
  // or the unit is still computing; hi/lo are only then in program order.
  assign rd_stall  = rd_req & ((count != '0) | md_busy);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset: it is only read where count says it is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: in_op, a: in_a, b: in_b};
    end
  end

  always_comb begin
    head     = mem[rd_ptr];
    md_start = 1'b0;
    md_op    = OP_NONE;
    md_a     = '0;
    md_b     = '0;
    if (issue) begin
      md_op = head.op;
      md_a  = head.a;
      // mthi/mtlo are single-cycle writes of A: no Start, B forced to zero.
      if (head.op != OP_MTHI && head.op != OP_MTLO) begin
        md_start = 1'b1;
        md_b     = head.b;
      end
    end
  end

endmodule

// File: tb/tb_md_issue_buffer.sv
module tb_md_issue_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [2:0]    in_op;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  logic          in_ready;
  logic          md_busy;
  logic          md_start;
  logic [2:0]    md_op;
  logic [31:0]   md_a;
  logic [31:0]   md_b;
  logic          rd_req;
  logic          rd_stall;
  logic [AW:0]   occupancy;

  md_issue_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ready  (in_ready),
    .md_busy   (md_busy),
    .md_start  (md_start),
    .md_op     (md_op),
    .md_a      (md_a),
    .md_b      (md_b),
    .rd_req    (rd_req),
    .rd_stall  (rd_stall),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } ent_t;

  // Reference: an ordered list of pending ops plus a behavioural MD unit.
  ent_t        q[$];
  int          busy_cnt = 0;
  logic [31:0] hi = 0;
  logic [31:0] lo = 0;
  bit          en = 0;
  int          tests = 0;
  int          fails = 0;

  // Values sampled from the DUT in the most recent cycle.
  logic          s_ready, s_start, s_stall;
  logic [2:0]    s_op;
  logic [31:0]   s_a, s_b;
  logic [AW:0]   s_occ;

  logic [2:0] ops [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b100, 3'b101};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MD unit: starts compute final hi/lo up front and then hold busy for the
  // op's latency; mthi/mtlo write immediately.
  task automatic md_apply();
    logic [63:0] p;
    if (s_start === 1'b1) begin
      case (s_op)
        3'b000: begin p = {32'b0, s_a} * {32'b0, s_b}; {hi, lo} = p; busy_cnt = 5; end
        3'b001: begin p = $signed({{32{s_a[31]}}, s_a}) * $signed({{32{s_b[31]}}, s_b});
                      {hi, lo} = p; busy_cnt = 5; end
        3'b110: begin p = $signed({{32{s_a[31]}}, s_a}) * $signed({{32{s_b[31]}}, s_b});
                      {hi, lo} = {hi, lo} + p; busy_cnt = 5; end
        3'b010: begin lo = s_a / s_b; hi = s_a % s_b; busy_cnt = 10; end
        3'b011: begin lo = $signed(s_a) / $signed(s_b); hi = $signed(s_a) % $signed(s_b);
                      busy_cnt = 10; end
        default: busy_cnt = 0;
      endcase
    end else begin
      if (s_op === 3'b100) hi = s_a;
      if (s_op === 3'b101) lo = s_a;
      if (busy_cnt > 0) busy_cnt--;
    end
  endtask

  task automatic cycle(input bit v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit rq, input bit rst);
    bit   e_ready, e_issue, e_stall, e_start;
    logic [2:0]  e_op;
    logic [31:0] e_a, e_b;
    @(negedge clk);
    in_valid = v; in_op = op; in_a = a; in_b = b; rd_req = rq; reset = rst;
    md_busy  = (busy_cnt != 0);
    #1;
    s_ready = in_ready; s_start = md_start; s_stall = rd_stall;
    s_op = md_op; s_a = md_a; s_b = md_b; s_occ = occupancy;
    e_ready = (q.size() != DEPTH);
    e_issue = (q.size() != 0) && !md_busy;
    e_stall = rq && ((q.size() != 0) || md_busy);
    e_start = 0; e_op = 3'b111; e_a = 0; e_b = 0;
    if (e_issue) begin
      e_op = q[0].op; e_a = q[0].a;
      if (q[0].op != 3'b100 && q[0].op != 3'b101) begin
        e_start = 1; e_b = q[0].b;
      end
    end
    if (en) begin
      chk("in_ready",  32'(s_ready), 32'(e_ready));
      chk("md_start",  32'(s_start), 32'(e_start));
      chk("md_op",     32'(s_op),    32'(e_op));
      chk("md_a",      s_a,          e_a);
      chk("md_b",      s_b,          e_b);
      chk("rd_stall",  32'(s_stall), 32'(e_stall));
      chk("occupancy", 32'(s_occ),   q.size());
    end
    @(posedge clk);
    md_apply();
    if (e_issue) void'(q.pop_front());
    if (rst) q.delete();
    else if (v && e_ready && op != 3'b111) q.push_back('{op, a, b});
  endtask

  task automatic idle();
    cycle(0, 3'b111, 0, 0, 0, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy_cnt != 0) && n < 60) begin
      idle();
      n++;
    end
    chk("drain_timeout", 32'(n < 60), 1);
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (busy_cnt != 0 && n < 20) begin
      idle();
      n++;
    end
    chk("busy_timeout", 32'(n < 20), 1);
  endtask

  initial begin
    int n;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [31:0] drain_a [4];

    reset = 1; in_valid = 0; in_op = 3'b111; in_a = 0; in_b = 0;
    rd_req = 0; md_busy = 0;
    cycle(0, 3'b111, 0, 0, 0, 1);
    en = 1;

    // Reset state
    idle();
    chk("rst_occ", 32'(s_occ), 0);
    chk("rst_start", 32'(s_start), 0);
    chk("rst_op", 32'(s_op), 32'(3'b111));
    chk("rst_a", s_a, 0);
    chk("rst_b", s_b, 0);
    chk("rst_ready", 32'(s_ready), 1);

    // multu 3*5 on an idle unit; read stalls until busy falls
    cycle(1, 3'b000, 3, 5, 0, 0);
    cycle(0, 3'b111, 0, 0, 1, 0);
    chk("t1_start", 32'(s_start), 1);
    chk("t1_op", 32'(s_op), 0);
    chk("t1_a", s_a, 3);
    chk("t1_b", s_b, 5);
    chk("t1_occ", 32'(s_occ), 1);
    chk("t1_stall_pop", 32'(s_stall), 1);
    n = 0;
    do begin
      cycle(0, 3'b111, 0, 0, 1, 0);
      n++;
    end while (s_stall === 1'b1 && n < 20);
    chk("t1_stall_cycles", n, 6);
    chk("t1_hi", hi, 0);
    chk("t1_lo", lo, 15);

    // div -7/2 then mthi; mthi waits out the divide
    cycle(1, 3'b011, 32'hFFFF_FFF9, 2, 0, 0);
    cycle(1, 3'b100, 32'h1234, 0, 0, 0);
    chk("t2_div_start", 32'(s_start), 1);
    chk("t2_div_op", 32'(s_op), 3);
    for (int i = 0; i < 10; i++) begin
      idle();
      chk("t2_mthi_held", 32'(s_op), 32'(3'b111));
    end
    idle();
    chk("t2_mthi_op", 32'(s_op), 32'(3'b100));
    chk("t2_mthi_a", s_a, 32'h1234);
    wait_idle();
    chk("t2_hi", hi, 32'h1234);
    chk("t2_lo", lo, 32'hFFFF_FFFD);

    // Fill to DEPTH while busy, fifth push refused, drain in order across wrap
    drain_a = '{32'h11, 32'h22, 32'h33, 32'h44};
    cycle(1, 3'b000, 1, 1, 0, 0);
    cycle(1, 3'b100, drain_a[0], 32'hBAD, 0, 0);
    cycle(1, 3'b101, drain_a[1], 0, 0, 0);
    cycle(1, 3'b100, drain_a[2], 0, 0, 0);
    cycle(1, 3'b101, drain_a[3], 0, 0, 0);
    cycle(1, 3'b100, 32'h55, 0, 0, 0);
    chk("t3_full_ready", 32'(s_ready), 0);
    chk("t3_full_occ", 32'(s_occ), 4);
    wait_not_busy();
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("t3_drain_op", 32'(s_op), (i % 2 == 0) ? 32'(3'b100) : 32'(3'b101));
      chk("t3_drain_a", s_a, drain_a[i]);
      chk("t3_drain_b", s_b, 0);
    end
    idle();
    chk("t3_empty_occ", 32'(s_occ), 0);

    // Push and pop together at occupancy 2
    cycle(1, 3'b001, 2, 3, 0, 0);
    cycle(1, 3'b100, 32'h55, 0, 0, 0);
    cycle(1, 3'b101, 32'h66, 0, 0, 0);
    wait_not_busy();
    cycle(1, 3'b100, 32'h77, 0, 0, 0);
    chk("t4_occ_before", 32'(s_occ), 2);
    chk("t4_issue_a", s_a, 32'h55);
    idle();
    chk("t4_occ_after", 32'(s_occ), 2);
    chk("t4_next_a", s_a, 32'h66);
    wait_idle();

    // in_op=111 is discarded
    cycle(1, 3'b111, 32'hDEAD, 32'hBEEF, 0, 0);
    idle();
    chk("t5_occ", 32'(s_occ), 0);
    chk("t5_start", 32'(s_start), 0);

    // Reset at occupancy 3 while busy
    cycle(1, 3'b001, 1, 2, 0, 0);
    cycle(1, 3'b100, 1, 0, 0, 0);
    cycle(1, 3'b100, 2, 0, 0, 0);
    cycle(1, 3'b100, 3, 0, 0, 0);
    cycle(0, 3'b111, 0, 0, 0, 1);
    chk("t6_occ_pre", 32'(s_occ), 3);
    cycle(1, 3'b000, 4, 5, 0, 0);
    chk("t6_occ_post", 32'(s_occ), 0);
    chk("t6_op_post", 32'(s_op), 32'(3'b111));
    chk("t6_start_post", 32'(s_start), 0);
    idle();
    chk("t6_held_busy", 32'(s_start), 0);
    chk("t6_held_occ", 32'(s_occ), 1);
    wait_idle();
    chk("t6_lo", lo, 20);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r_op = ($urandom_range(0, 7) == 0) ? 3'b111 : ops[$urandom_range(0, 6)];
      r_a  = $urandom;
      r_b  = $urandom;
      if ((r_op == 3'b010 || r_op == 3'b011) && r_b == 0) r_b = 1;
      cycle($urandom_range(0, 2) != 0, r_op, r_a, r_b,
            $urandom_range(0, 1) == 1, $urandom_range(0, 59) == 0);
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
